// File: rtl/layer_wr_ctl.sv
// layer_wr_ctl
//   Write controller between the SPI byte receiver and the per-layer pixel
//   RAM banks. Command bytes select an address-RAM frame (broadcast to every
//   layer) or a colour-data frame (layer by layer, colour lanes MSB first).
//   Data bytes advance the pixel address / colour lane / layer mask.
//
// Ports
//   clk_in         clock, rising edge
//   rst_in         asynchronous active-high reset
//   dc_in          0 = command byte, 1 = data byte (qualified by byte_rdy_in)
//   byte_rdy_in    one-cycle byte strobe
//   byte_data_in   received byte
//   frame_rdy_out  pulse: complete colour frame written
//   frame_err_out  pulse: frame in progress aborted by a command byte
//   busy_out       high while an address or data frame is open
//   wr_addr_out    RAM pixel address for the next accepted byte
//   byte_en_out    {address lane, one-hot colour lanes} for the next byte
//   layer_en_out   per-layer write strobes (mask gated by byte_rdy_in)
module layer_wr_ctl #(
  parameter int         LAYERS   = 8,
  parameter int         ADDR_W   = 6,
  parameter int         COLORS   = 3,
  parameter logic [7:0] ADDR_CMD = 8'hcc,
  parameter logic [7:0] DATA_CMD = 8'hda
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              dc_in,
  input  logic              byte_rdy_in,
  input  logic [7:0]        byte_data_in,
  output logic              frame_rdy_out,
  output logic              frame_err_out,
  output logic              busy_out,
  output logic [ADDR_W-1:0] wr_addr_out,
  output logic [COLORS:0]   byte_en_out,
  output logic [LAYERS-1:0] layer_en_out
);

  typedef enum logic [1:0] {IDLE, ADDR_WR, DATA_WR} state_t;

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] wr_addr, wr_addr_nx;
  logic              addr_en, addr_en_nx;
  logic [COLORS-1:0] colour, colour_nx, colour_rot;
  logic [LAYERS-1:0] mask, mask_nx;
  logic              started, started_nx;
  logic              frame_rdy, frame_rdy_nx;
  logic              frame_err, frame_err_nx;
  logic              cmd_byte, data_byte, addr_last;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state     <= IDLE;
      wr_addr   <= '0;
      addr_en   <= 1'b0;
      colour    <= '0;
      mask      <= '0;
      started   <= 1'b0;
      frame_rdy <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nx;
      wr_addr   <= wr_addr_nx;
      addr_en   <= addr_en_nx;
      colour    <= colour_nx;
      mask      <= mask_nx;
      started   <= started_nx;
      frame_rdy <= frame_rdy_nx;
      frame_err <= frame_err_nx;
    end
  end

  always_comb begin
    cmd_byte  = byte_rdy_in & ~dc_in;
    data_byte = byte_rdy_in & dc_in;
    addr_last = (wr_addr == ADDR_MAX);
    // rotate right; written bitwise so COLORS=1 degenerates to "stays set"
    colour_rot = colour >> 1;
    colour_rot[COLORS-1] = colour[0];

    state_nx     = state;
    wr_addr_nx   = wr_addr;
    addr_en_nx   = addr_en;
    colour_nx    = colour;
    mask_nx      = mask;
    started_nx   = started;
    frame_rdy_nx = 1'b0;
    frame_err_nx = 1'b0;

    if (cmd_byte) begin
      wr_addr_nx   = '0;
      started_nx   = 1'b0;
      // only a frame that has actually received data counts as aborted
      frame_err_nx = (state != IDLE) && started;
      if (byte_data_in == ADDR_CMD) begin
        state_nx   = ADDR_WR;
        addr_en_nx = 1'b1;
        colour_nx  = '0;
        mask_nx    = '1;
      end else if (byte_data_in == DATA_CMD) begin
        state_nx   = DATA_WR;
        addr_en_nx = 1'b0;
        colour_nx  = '0;
        colour_nx[COLORS-1] = 1'b1;
        mask_nx    = '0;
        mask_nx[0] = 1'b1;
      end else begin
        state_nx   = IDLE;
        addr_en_nx = 1'b0;
        colour_nx  = '0;
        mask_nx    = '0;
      end
    end else if (data_byte) begin
      case (state)
        ADDR_WR: begin
          started_nx = 1'b1;
          if (addr_last) begin
            wr_addr_nx = '0;
            mask_nx    = '0;
            addr_en_nx = 1'b0;
            state_nx   = IDLE;
          end else begin
            wr_addr_nx = wr_addr + ADDR_W'(1);
          end
        end
        DATA_WR: begin
          started_nx = 1'b1;
          colour_nx  = colour_rot;
          // last colour lane of the pixel: move to next pixel / layer
          if (colour[0]) begin
            if (addr_last) begin
              wr_addr_nx = '0;
              if (mask[LAYERS-1]) begin
                mask_nx      = '0;
                colour_nx    = '0;
                state_nx     = IDLE;
                frame_rdy_nx = 1'b1;
              end else begin
                // top bit is clear here, so a shift is the left rotation
                mask_nx = mask << 1;
              end
            end else begin
              wr_addr_nx = wr_addr + ADDR_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign frame_rdy_out = frame_rdy;
  assign frame_err_out = frame_err;
  assign busy_out      = (state != IDLE);
  assign wr_addr_out   = wr_addr;
  assign byte_en_out   = {addr_en, colour};
  assign layer_en_out  = mask & {LAYERS{byte_rdy_in}};

endmodule

// File: tb/tb_layer_wr_ctl.sv
module tb_layer_wr_ctl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dc = 1'b0;
  logic       rdy = 1'b0;
  logic [7:0] data = 8'h00;

  // default-parameter instance
  logic       frdy, ferr, busy;
  logic [5:0] waddr;
  logic [3:0] ben;
  logic [7:0] len;

  // small instance: 4 layers, 8 pixels, 1 colour
  logic       frdy2, ferr2, busy2;
  logic [2:0] waddr2;
  logic [1:0] ben2;
  logic [3:0] len2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  layer_wr_ctl dut (
    .clk_in(clk), .rst_in(rst), .dc_in(dc), .byte_rdy_in(rdy),
    .byte_data_in(data), .frame_rdy_out(frdy), .frame_err_out(ferr),
    .busy_out(busy), .wr_addr_out(waddr), .byte_en_out(ben),
    .layer_en_out(len)
  );

  layer_wr_ctl #(.LAYERS(4), .ADDR_W(3), .COLORS(1)) dut2 (
    .clk_in(clk), .rst_in(rst), .dc_in(dc), .byte_rdy_in(rdy),
    .byte_data_in(data), .frame_rdy_out(frdy2), .frame_err_out(ferr2),
    .busy_out(busy2), .wr_addr_out(waddr2), .byte_en_out(ben2),
    .layer_en_out(len2)
  );

  wire [20:0] obs = {waddr, ben, len, busy, frdy, ferr};

  // Reference model: frame mode plus number of bytes accepted in the frame.
  // Address/lane/layer come straight from the byte index k:
  //   pixel = (k/3)%64, lane = 2 - k%3, layer = k/192.
  int         m_mode;   // 0 idle, 1 address frame, 2 data frame
  int         m_k;
  logic       m_frdy, m_ferr;
  logic [20:0] expv;

  function automatic logic [20:0] model_exp(input logic r);
    logic [5:0] a;
    logic [3:0] be;
    logic [7:0] le;
    logic       b;
    a = '0; be = '0; le = '0; b = 1'b0;
    if (m_mode == 1) begin
      a  = 6'(m_k);
      be = 4'b1000;
      le = r ? 8'hff : 8'h00;
      b  = 1'b1;
    end else if (m_mode == 2) begin
      a  = 6'((m_k / 3) % 64);
      be = 4'(1 << (2 - (m_k % 3)));
      le = r ? 8'(1 << (m_k / 192)) : 8'h00;
      b  = 1'b1;
    end
    return {a, be, le, b, m_frdy, m_ferr};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_k = 0; m_frdy = 1'b0; m_ferr = 1'b0;
  endtask

  // apply the currently driven byte to the model (the DUT takes it at posedge)
  task automatic commit();
    m_frdy = 1'b0;
    m_ferr = 1'b0;
    if (rdy && !dc) begin
      m_ferr = (m_mode != 0) && (m_k > 0);
      m_k = 0;
      m_mode = (data == 8'hcc) ? 1 : (data == 8'hda) ? 2 : 0;
    end else if (rdy && dc && m_mode != 0) begin
      m_k++;
      if (m_mode == 1 && m_k == 64) begin
        m_mode = 0; m_k = 0;
      end else if (m_mode == 2 && m_k == 1536) begin
        m_mode = 0; m_k = 0; m_frdy = 1'b1;
      end
    end
  endtask

  task automatic drive(input logic r, input logic d, input logic [7:0] b);
    @(negedge clk);
    rdy = r; dc = d; data = b;
    #1;
    expv = model_exp(r);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (obs !== 21'h0) begin
      errors++; $display("FAIL reset_held got=%h want=%h", obs, 21'h0);
    end
    rst = 1'b0;
    model_reset();
    drive(1'b1, 1'b1, 8'h3c);  // data byte in IDLE: ignored
    checks++;
    if (obs !== expv) begin
      errors++; $display("FAIL reset_idle_data got=%h want=%h", obs, expv);
    end
    commit();
  endtask

  task automatic test_addr_frame();
    int n = 0;
    drive(1'b1, 1'b0, 8'hcc);
    commit();
    while (n < 64) begin
      if ($urandom_range(0, 3) == 0) drive(1'b0, 1'b1, 8'h00);
      else begin drive(1'b1, 1'b1, 8'($urandom)); n++; end
      checks++;
      if (obs !== expv) begin
        errors++; $display("FAIL addr_frame n=%0d got=%h want=%h", n, obs, expv);
      end
      commit();
    end
    drive(1'b0, 1'b1, 8'h00);
    checks++;
    if ({busy, waddr, frdy, ferr} !== 9'h0) begin
      errors++; $display("FAIL addr_frame_end got=%h want=%h", {busy, waddr, frdy, ferr}, 9'h0);
    end
    commit();
  endtask

  task automatic test_data_frame();
    int pulses = 0;
    drive(1'b1, 1'b0, 8'hda);
    commit();
    for (int i = 0; i < 1536; i++) begin
      drive(1'b1, 1'b1, 8'($urandom));
      if (frdy) pulses++;
      checks++;
      if (obs !== expv) begin
        errors++; $display("FAIL data_frame byte=%0d got=%h want=%h", i, obs, expv);
      end
      commit();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 8'h00);
      if (frdy) pulses++;
      checks++;
      if (obs !== expv) begin
        errors++; $display("FAIL data_frame_tail c=%0d got=%h want=%h", i, obs, expv);
      end
      commit();
    end
    checks++;
    if (pulses != 1) begin
      errors++; $display("FAIL data_frame_pulses got=%0d want=1", pulses);
    end
  endtask

  task automatic test_abort();
    int lens[2];
    lens[0] = 100;
    lens[1] = $urandom_range(1, 1535);
    for (int t = 0; t < 2; t++) begin
      drive(1'b1, 1'b0, 8'hda);
      commit();
      for (int i = 0; i < lens[t]; i++) begin
        drive(1'b1, 1'b1, 8'($urandom));
        checks++;
        if (obs !== expv) begin
          errors++; $display("FAIL abort_fill n=%0d got=%h want=%h", i, obs, expv);
        end
        commit();
      end
      drive(1'b1, 1'b0, 8'hda);
      commit();
      drive(1'b1, 1'b1, 8'h00);
      checks++;
      if ({ferr, frdy, waddr, ben, len} !== {1'b1, 1'b0, 6'd0, 4'b0100, 8'h01}) begin
        errors++;
        $display("FAIL abort len=%0d got=%h want=%h", lens[t], {ferr, frdy, waddr, ben, len},
                 {1'b1, 1'b0, 6'd0, 4'b0100, 8'h01});
      end
      commit();
    end
  endtask

  task automatic test_unknown();
    drive(1'b1, 1'b0, 8'hda);
    commit();
    drive(1'b1, 1'b0, 8'h55);
    commit();
    drive(1'b0, 1'b1, 8'h00);
    checks++;
    if ({ferr, busy} !== 2'b00) begin
      errors++; $display("FAIL unknown_cmd got=%b want=00", {ferr, busy});
    end
    commit();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 8'($urandom));
      checks++;
      if (len !== 8'h00 || obs !== expv) begin
        errors++; $display("FAIL unknown_data i=%0d got=%h want=%h", i, obs, expv);
      end
      commit();
    end
  endtask

  task automatic test_random();
    logic [7:0] cmds[4];
    logic       r, d;
    logic [7:0] b;
    cmds[0] = 8'hcc; cmds[1] = 8'hda; cmds[2] = 8'h55; cmds[3] = 8'h00;
    for (int i = 0; i < 800; i++) begin
      r = ($urandom_range(0, 3) != 0);
      d = ($urandom_range(0, 39) != 0);
      b = d ? 8'($urandom) : cmds[$urandom_range(0, 3)];
      if (!d && b == 8'h00) b = 8'($urandom);
      drive(r, d, b);
      checks++;
      if (obs !== expv) begin
        errors++; $display("FAIL random i=%0d got=%h want=%h", i, obs, expv);
      end
      commit();
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b0, 8'hda);
    commit();
    for (int i = 0; i < 699; i++) begin
      drive(1'b1, 1'b1, 8'($urandom));
      commit();
    end
    drive(1'b1, 1'b1, 8'h77);  // byte 700
    checks++;
    if (obs !== expv) begin
      errors++; $display("FAIL reset_mid_pre got=%h want=%h", obs, expv);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (obs !== 21'h0) begin
      errors++; $display("FAIL reset_mid_async got=%h want=%h", obs, 21'h0);
    end
    model_reset();
    drive(1'b0, 1'b1, 8'h00);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 8'h00);
      checks++;
      if (obs !== 21'h0) begin
        errors++; $display("FAIL reset_mid_after c=%0d got=%h want=%h", i, obs, 21'h0);
      end
      commit();
    end
  endtask

  task automatic test_small();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    model_reset();
    drive(1'b1, 1'b0, 8'hda);
    commit();
    for (int k = 0; k < 32; k++) begin
      drive(1'b1, 1'b1, 8'($urandom));
      checks++;
      if ({waddr2, ben2, len2} !== {3'(k % 8), 2'b01, 4'(1 << (k / 8))}) begin
        errors++;
        $display("FAIL small k=%0d got=%h want=%h", k, {waddr2, ben2, len2},
                 {3'(k % 8), 2'b01, 4'(1 << (k / 8))});
      end
      commit();
    end
    drive(1'b0, 1'b1, 8'h00);
    checks++;
    if ({frdy2, ferr2, busy2, waddr2, ben2} !== {1'b1, 1'b0, 1'b0, 3'd0, 2'b00}) begin
      errors++; $display("FAIL small_end got=%h want=%h", {frdy2, ferr2, busy2, waddr2, ben2},
                         {1'b1, 1'b0, 1'b0, 3'd0, 2'b00});
    end
    commit();
    drive(1'b0, 1'b1, 8'h00);
    checks++;
    if (frdy2 !== 1'b0) begin
      errors++; $display("FAIL small_pulse_width got=%b want=0", frdy2);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_addr_frame();
    test_data_frame();
    test_abort();
    test_unknown();
    test_random();
    test_reset_mid();
    test_small();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
